// File: rtl/asignador_parqueadero.sv
// Parking spot assigner: debounces six occupancy sensors, reserves the lowest free
// spot on each entry request, announces it on pasignado/led, and reports free-spot counts.
module asignador_parqueadero #(
    parameter int N_DEB     = 4,
    parameter int LED_HOLD  = 4,
    parameter int T_RESERVA = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       solicitud,
    input  logic [5:0] sensores,
    output logic [3:0] pasignado,
    output logic       led,
    output logic       lleno,
    output logic [2:0] libres
);

    localparam int DEB_W = $clog2(N_DEB + 1);
    localparam int LED_W = $clog2(LED_HOLD + 1);
    localparam int TMR_W = $clog2(T_RESERVA + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(N_DEB - 1);
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_HOLD - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(T_RESERVA - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSCA  = 2'd1,
        AVISO  = 2'd2,
        ESPERA = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [5:0]       occ_q,       occ_d;
    logic [5:0]       reserved_q,  reserved_d;
    logic [DEB_W-1:0] deb_cnt_q [6];
    logic [DEB_W-1:0] deb_cnt_d [6];
    logic             sol_d_q;
    logic             req_q,       req_d;
    logic [3:0]       pasignado_q, pasignado_d;
    logic             led_q,       led_d;
    logic [2:0]       spot_q,      spot_d;
    logic [LED_W-1:0] led_cnt_q,   led_cnt_d;
    logic [TMR_W-1:0] tmr_q,       tmr_d;
    logic [2:0]       libres_q,    libres_d;
    logic             lleno_q,     lleno_d;

    logic [5:0]       free;
    logic [2:0]       sel_idx;

    // ------------------------------------------------------------------
    // Debounce: a bit flips only after N_DEB consecutive differing samples.
    // ------------------------------------------------------------------
    always_comb begin
        occ_d = occ_q;
        for (int i = 0; i < 6; i++) begin
            deb_cnt_d[i] = '0;
            if (sensores[i] != occ_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    occ_d[i] = ~occ_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Free-spot vector, lowest-index selection and population count.
    // ------------------------------------------------------------------
    assign free = ~occ_q & ~reserved_q;

    always_comb begin
        sel_idx = '0;
        for (int i = 5; i >= 0; i--) begin
            if (free[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        libres_d = '0;
        for (int i = 0; i < 6; i++) begin
            libres_d = libres_d + {2'b00, free[i]};
        end
        lleno_d = (free == 6'b0);
    end

    // Registered edge detect, so a held level produces exactly one pulse.
    assign req_d = solicitud & ~sol_d_q;

    // ------------------------------------------------------------------
    // Assignment FSM: next state and registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        reserved_d  = reserved_q;
        pasignado_d = pasignado_q;
        led_d       = led_q;
        spot_d      = spot_q;
        led_cnt_d   = led_cnt_q;
        tmr_d       = tmr_q;

        unique case (state_q)
            IDLE: begin
                pasignado_d = 4'd0;
                led_d       = 1'b0;
                if (req_q) begin
                    state_d = BUSCA;
                end
            end

            BUSCA: begin
                if (free != 6'b0) begin
                    reserved_d[sel_idx] = 1'b1;
                    spot_d              = sel_idx;
                    pasignado_d         = 4'(sel_idx) + 4'd1;
                    led_d               = 1'b1;
                    led_cnt_d           = LED_LOAD;
                    state_d             = AVISO;
                end else begin
                    pasignado_d = 4'd0;
                    led_d       = 1'b0;
                    state_d     = IDLE;
                end
            end

            // The strobe always runs its full length, even if the car parks early.
            AVISO: begin
                if (led_cnt_q == '0) begin
                    led_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = ESPERA;
                end else begin
                    led_cnt_d = led_cnt_q - 1'b1;
                end
            end

            ESPERA: begin
                led_d = 1'b0;
                if (occ_q[spot_q] || (tmr_q == TMR_LAST)) begin
                    reserved_d[spot_q] = 1'b0;
                    pasignado_d        = 4'd0;
                    state_d            = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            reserved_q  <= '0;
            sol_d_q     <= 1'b0;
            req_q       <= 1'b0;
            pasignado_q <= 4'd0;
            led_q       <= 1'b0;
            spot_q      <= '0;
            led_cnt_q   <= '0;
            tmr_q       <= '0;
            libres_q    <= 3'd6;
            lleno_q     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            reserved_q  <= reserved_d;
            sol_d_q     <= solicitud;
            req_q       <= req_d;
            pasignado_q <= pasignado_d;
            led_q       <= led_d;
            spot_q      <= spot_d;
            led_cnt_q   <= led_cnt_d;
            tmr_q       <= tmr_d;
            libres_q    <= libres_d;
            lleno_q     <= lleno_d;
            for (int i = 0; i < 6; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign pasignado = pasignado_q;
    assign led       = led_q;
    assign libres    = libres_q;
    assign lleno     = lleno_q;

endmodule
